// File: rtl/alu_arbiter_if.sv
// Bundle of every signal that alu_arbiter exchanges with the outside world
// other than clk and rst.
//   req0_*  : execute-stage requester (valid/ready/op/a/b)
//   req1_*  : multi-cycle helper requester (valid/ready/op/a/b)
//   alu_*   : registered operands/opcode to the shared ALU and its result/overflow
//   resp_*  : response handshake (valid/ready) with owner id, data and error
//   flags   : architectural {Z, V, N}
// Modport "slave" is the arbiter's view; "master" is the view of the
// surroundings (requesters, ALU and response consumer together).
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_err;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [2:0]       flags;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, alu_err, resp_ready,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_op,
    output resp_valid, resp_id, resp_data, resp_err, flags
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, alu_err, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_op,
    input  resp_valid, resp_id, resp_data, resp_err, flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with round-robin arbitration.
// A granted op is registered into alu_in1/alu_in2/alu_op, the ALU result is
// captured one cycle later together with the overflow bit, and the response is
// held until the consumer takes it. The block also owns the Z/V/N flag register.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset (aborts any in-flight op)
//   bus  : alu_arbiter_if.slave, requester/ALU/response signals
// Parameters:
//   WIDTH    : datapath width
//   RST_LAST : last-grant pointer after reset (1 -> req0 wins the first tie)
module alu_arbiter #(
  parameter int WIDTH    = 16,
  parameter bit RST_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADSUB = 3'b111;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic [2:0]       flags_q, flags_d;   // {Z, V, N}

  logic grant0;
  logic grant1;
  logic res_zero;

  assign res_zero = (bus.alu_out == '0);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_op_d     = alu_op_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    flags_d      = flags_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      IDLE: begin
        // last_q names the previous winner; on a tie the other side goes.
        // The two terms are mutually exclusive, so at most one grant fires.
        grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
        if (grant0) begin
          alu_in1_d = bus.req0_a;
          alu_in2_d = bus.req0_b;
          alu_op_d  = bus.req0_op;
          resp_id_d = 1'b0;
          last_d    = 1'b0;
          state_d   = EXEC;
        end else if (grant1) begin
          alu_in1_d = bus.req1_a;
          alu_in2_d = bus.req1_b;
          alu_op_d  = bus.req1_op;
          resp_id_d = 1'b1;
          last_d    = 1'b1;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        resp_data_d  = bus.alu_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
        // Overflow is only meaningful for ADD/SUB; other ops report no error.
        resp_err_d   = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) ? bus.alu_err : 1'b0;
        case (alu_op_q)
          OP_ADD, OP_SUB: flags_d = {res_zero, bus.alu_err, bus.alu_out[WIDTH-1]};
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {res_zero, flags_q[1:0]};
          OP_RED, OP_PADSUB: flags_d = flags_q;
          default: flags_d = flags_q;
        endcase
      end

      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= RST_LAST;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      flags_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_op_q     <= alu_op_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.flags      = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and hand-computed
// expected responses, flags and grant orders.
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b010, RED = 3'b011;
  localparam logic [2:0] SLL = 3'b100, SRA = 3'b101, ROR = 3'b110, PADSUB = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16)) bus_if ();

  alu_arbiter #(.WIDTH(16), .RST_LAST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Behavioural ALU. RED and PADSUB raise err on purpose so the bench can see
  // that the arbiter ignores the overflow line for those ops.
  always_comb begin
    logic [15:0] a, b, r;
    logic [3:0]  s;
    a = bus_if.alu_in1;
    b = bus_if.alu_in2;
    s = b[3:0];
    r = 16'h0000;
    bus_if.alu_err = 1'b0;
    case (bus_if.alu_op)
      ADD: begin r = a + b; bus_if.alu_err = (a[15] == b[15]) && (r[15] != a[15]); end
      SUB: begin r = a - b; bus_if.alu_err = (a[15] != b[15]) && (r[15] != a[15]); end
      XOR: r = a ^ b;
      RED: begin r = {15'h0000, ^a}; bus_if.alu_err = 1'b1; end
      SLL: r = a << s;
      SRA: r = 16'($signed(a) >>> s);
      ROR: r = (a >> s) | (a << (5'd16 - {1'b0, s}));
      default: begin r = a - b; bus_if.alu_err = 1'b1; end
    endcase
    bus_if.alu_out = r;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (id == 1'b0) begin
      bus_if.req0_valid = v; bus_if.req0_op = op; bus_if.req0_a = a; bus_if.req0_b = b;
    end else begin
      bus_if.req1_valid = v; bus_if.req1_op = op; bus_if.req1_a = a; bus_if.req1_b = b;
    end
  endtask

  function automatic logic rdy(input bit id);
    return (id == 1'b0) ? bus_if.req0_ready : bus_if.req1_ready;
  endfunction

  // Called at a negedge with resp_ready=1; returns at a negedge with the
  // arbiter back in IDLE.
  task automatic run_single(input string tag, input bit id, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_data, input bit exp_err,
                            input logic [2:0] exp_flags);
    int n;
    set_req(id, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(id) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_grant"}, 32'(rdy(id)), 32'd1);
    check({tag, "_other_ready"}, 32'(rdy(~id)), 32'd0);
    @(negedge clk);
    set_req(id, 1'b0, op, a, b);
    // EXEC cycle: operands registered, no response yet.
    check({tag, "_exec_valid"}, 32'(bus_if.resp_valid), 32'd0);
    check({tag, "_alu_in1"}, 32'(bus_if.alu_in1), 32'(a));
    check({tag, "_alu_in2"}, 32'(bus_if.alu_in2), 32'(b));
    check({tag, "_alu_op"}, 32'(bus_if.alu_op), 32'(op));
    @(negedge clk);
    check({tag, "_resp_valid"}, 32'(bus_if.resp_valid), 32'd1);
    check({tag, "_resp_id"}, 32'(bus_if.resp_id), 32'(id));
    check({tag, "_resp_data"}, 32'(bus_if.resp_data), 32'(exp_data));
    check({tag, "_resp_err"}, 32'(bus_if.resp_err), 32'(exp_err));
    check({tag, "_flags"}, 32'(bus_if.flags), 32'(exp_flags));
    $display("op %s id=%0d op=%0d a=%h b=%h -> data=%h err=%0d flags=%b",
             tag, id, op, a, b, bus_if.resp_data, bus_if.resp_err, bus_if.flags);
    @(negedge clk);
    check({tag, "_consumed"}, 32'(bus_if.resp_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(bus_if.resp_valid), 32'd0);
    check({tag, "_id"}, 32'(bus_if.resp_id), 32'd0);
    check({tag, "_data"}, 32'(bus_if.resp_data), 32'd0);
    check({tag, "_err"}, 32'(bus_if.resp_err), 32'd0);
    check({tag, "_flags"}, 32'(bus_if.flags), 32'd0);
    check({tag, "_in1"}, 32'(bus_if.alu_in1), 32'd0);
    check({tag, "_in2"}, 32'(bus_if.alu_in2), 32'd0);
    check({tag, "_op"}, 32'(bus_if.alu_op), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_d[4];
    logic [2:0]  exp_f[4];
    bit          exp_g[4];
    logic [15:0] got_d[4];
    logic [2:0]  got_f[4];
    bit          got_g[4];
    int          gcyc[3];
    int          ng, nr;
    bit          drop;

    rst = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    bus_if.resp_ready = 1'b1;

    // ---- reset state, then ADD overflow
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    check("rst_ready0", 32'(bus_if.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus_if.req1_ready), 32'd0);
    rst = 1'b0;
    run_single("add_ovf", 1'b0, ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 3'b011);

    // ---- flag-holding and Z-only ops
    run_single("red", 1'b1, RED, 16'h1234, 16'h0000, 16'h0001, 1'b0, 3'b011);
    run_single("padsub", 1'b1, PADSUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 3'b011);
    run_single("xor_zero", 1'b0, XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 3'b111);
    run_single("sra", 1'b0, SRA, 16'h8000, 16'h0004, 16'hF800, 1'b0, 3'b011);
    run_single("ror", 1'b1, ROR, 16'h0001, 16'h0001, 16'h8000, 1'b0, 3'b011);

    // ---- backpressure: response held 5 cycles, pending req0 waits
    bus_if.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, ADD, 16'h0001, 16'h0002);
    #1;
    check("bp_grant", 32'(bus_if.req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b1, ADD, 16'h0003, 16'h0004);
    #1;
    check("bp_exec_ready0", 32'(bus_if.req0_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", 32'(bus_if.resp_valid), 32'd1);
      check("bp_hold_data", 32'(bus_if.resp_data), 32'h0003);
      check("bp_hold_flags", 32'(bus_if.flags), 32'd0);
      check("bp_hold_ready0", 32'(bus_if.req0_ready), 32'd0);
      check("bp_hold_ready1", 32'(bus_if.req1_ready), 32'd0);
      @(negedge clk);
    end
    $display("op bp id=0 data=%h held under backpressure", bus_if.resp_data);
    bus_if.resp_ready = 1'b1;
    #1;
    check("bp_release_ready0", 32'(bus_if.req0_ready), 32'd0);
    check("bp_release_valid", 32'(bus_if.resp_valid), 32'd1);
    @(negedge clk);
    #1;
    check("bp_after_valid", 32'(bus_if.resp_valid), 32'd0);
    check("bp_after_ready0", 32'(bus_if.req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, ADD, 16'h0003, 16'h0004);
    check("bp2_in1", 32'(bus_if.alu_in1), 32'h0003);
    @(negedge clk);
    check("bp2_valid", 32'(bus_if.resp_valid), 32'd1);
    check("bp2_data", 32'(bus_if.resp_data), 32'h0007);
    check("bp2_flags", 32'(bus_if.flags), 32'd0);
    $display("op bp2 id=0 data=%h flags=%b", bus_if.resp_data, bus_if.flags);
    @(negedge clk);

    // ---- reset during EXEC aborts the op
    run_single("sub_neg", 1'b0, SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 3'b001);
    set_req(1'b1, 1'b1, ADD, 16'h0001, 16'h0001);
    #1;
    check("abort_grant", 32'(bus_if.req1_ready), 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, ADD, 16'h0001, 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus_if.resp_valid), 32'd0);
    end
    $display("op abort id=1 ADD 1+1 aborted by reset");

    // ---- both requesters valid every cycle: 0,1,0,1
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_d = '{16'h0000, 16'h0FF0, 16'h0000, 16'h0FF0};
    exp_f = '{3'b100, 3'b000, 3'b100, 3'b000};
    set_req(1'b0, 1'b1, SUB, 16'h0005, 16'h0005);
    set_req(1'b1, 1'b1, XOR, 16'h00FF, 16'h0F0F);
    ng = 0; nr = 0; drop = 1'b0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      check("rr_one_ready", 32'(bus_if.req0_ready & bus_if.req1_ready), 32'd0);
      if ((bus_if.req0_ready | bus_if.req1_ready) && ng < 4) begin
        got_g[ng] = bus_if.req1_ready;
        ng++;
        if (ng == 4) drop = 1'b1;
      end
      if (bus_if.resp_valid && nr < 4) begin
        got_d[nr] = bus_if.resp_data;
        got_f[nr] = bus_if.flags;
        $display("op rr id=%0d data=%h flags=%b", bus_if.resp_id, bus_if.resp_data, bus_if.flags);
        nr++;
      end
      @(negedge clk);
      if (drop) begin
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
      end
    end
    check("rr_grants", 32'(ng), 32'd4);
    check("rr_resps", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check("rr_grant_id", 32'(got_g[i]), 32'(exp_g[i]));
      if (i < nr) begin
        check("rr_data", 32'(got_d[i]), 32'(exp_d[i]));
        check("rr_flags", 32'(got_f[i]), 32'(exp_f[i]));
      end
    end

    // ---- lone req1, back-to-back SLL, one grant per 3 cycles
    set_req(1'b1, 1'b1, SLL, 16'h0001, 16'h0004);
    ng = 0; nr = 0; drop = 1'b0;
    for (int c = 0; c < 40 && nr < 3; c++) begin
      #1;
      check("lone_ready0", 32'(bus_if.req0_ready), 32'd0);
      if (bus_if.req1_ready && ng < 3) begin
        gcyc[ng] = c;
        ng++;
        if (ng == 3) drop = 1'b1;
      end
      if (bus_if.resp_valid && nr < 3) begin
        check("lone_id", 32'(bus_if.resp_id), 32'd1);
        check("lone_data", 32'(bus_if.resp_data), 32'h0010);
        check("lone_flags", 32'(bus_if.flags), 32'd0);
        $display("op lone id=%0d data=%h flags=%b", bus_if.resp_id, bus_if.resp_data, bus_if.flags);
        nr++;
      end
      @(negedge clk);
      if (drop) bus_if.req1_valid = 1'b0;
    end
    check("lone_grants", 32'(ng), 32'd3);
    check("lone_resps", 32'(nr), 32'd3);
    if (ng == 3) begin
      check("lone_gap1", 32'(gcyc[1] - gcyc[0]), 32'd3);
      check("lone_gap2", 32'(gcyc[2] - gcyc[1]), 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
